// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator for the ALU T path, one bit position per clock.
// Latency: done pulses N+2 cycles after start is driven (N forced to 0 for NOSHIFT/undefined modes).
// Backpressure: none; start is ignored while busy, so the issuer must stall on busy.
module seq_shifter #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] T,
    input  logic [2:0]            shiftCtrl,
    input  logic [AMT_WIDTH-1:0]  shamt,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  carry,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] NOSHIFT = 3'b000;
    localparam logic [2:0] LSR     = 3'b001;
    localparam logic [2:0] LSL     = 3'b010;
    localparam logic [2:0] ASR     = 3'b011;
    localparam logic [2:0] ROR     = 3'b100;
    localparam logic [2:0] ROL     = 3'b101;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] work, work_nx;
    logic [AMT_WIDTH-1:0]  cnt, cnt_nx;
    logic [2:0]            mode, mode_nx;
    logic                  cbit, cbit_nx;
    logic [DATA_WIDTH-1:0] result_nx;
    logic                  carry_nx, zero_nx, done_nx;
    logic                  mode_shifts;

    assign busy        = (state == SHIFT);
    assign mode_shifts = (shiftCtrl >= LSR) && (shiftCtrl <= ROL);

    always_comb begin
        state_nx  = state;
        work_nx   = work;
        cnt_nx    = cnt;
        mode_nx   = mode;
        cbit_nx   = cbit;
        result_nx = Result;
        carry_nx  = carry;
        zero_nx   = zero;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nx  = T;
                    mode_nx  = shiftCtrl;
                    cbit_nx  = 1'b0;
                    // Non-shifting modes finish after the single writeback cycle.
                    cnt_nx   = mode_shifts ? shamt : '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    case (mode)
                        LSR: begin
                            work_nx = {1'b0, work[DATA_WIDTH-1:1]};
                            cbit_nx = work[0];
                        end
                        LSL: begin
                            work_nx = {work[DATA_WIDTH-2:0], 1'b0};
                            cbit_nx = work[DATA_WIDTH-1];
                        end
                        ASR: begin
                            work_nx = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
                            cbit_nx = work[0];
                        end
                        ROR: begin
                            work_nx = {work[0], work[DATA_WIDTH-1:1]};
                            cbit_nx = work[0];
                        end
                        ROL: begin
                            work_nx = {work[DATA_WIDTH-2:0], work[DATA_WIDTH-1]};
                            cbit_nx = work[DATA_WIDTH-1];
                        end
                        default: ;
                    endcase
                    cnt_nx = cnt - AMT_WIDTH'(1);
                end else begin
                    result_nx = work;
                    carry_nx  = cbit;
                    zero_nx   = (work == '0);
                    done_nx   = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            mode   <= NOSHIFT;
            cbit   <= 1'b0;
            Result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            work   <= work_nx;
            cnt    <= cnt_nx;
            mode   <= mode_nx;
            cbit   <= cbit_nx;
            Result <= result_nx;
            carry  <= carry_nx;
            zero   <= zero_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: arithmetic reference model checked every cycle, plus literal vectors.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic [15:0] T = 16'hFFFF;
    logic [2:0]  shiftCtrl = 3'b010;
    logic [4:0]  shamt = 5'd1;
    logic [15:0] Result;
    logic        carry, zero, busy, done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    seq_shifter #(.DATA_WIDTH(16), .AMT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .T(T), .shiftCtrl(shiftCtrl), .shamt(shamt),
        .Result(Result), .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Closed-form result of shifting t by n positions in mode m.
    function automatic void ref_op(input logic [2:0] m, input logic [15:0] t, input logic [4:0] n,
                                   output logic [15:0] r, output logic c, output int neff);
        logic [31:0]        tt;
        logic signed [15:0] s;
        int                 rr, k;
        tt   = {t, t};
        s    = t;
        rr   = int'(n) % 16;
        k    = (n > 16) ? 16 : int'(n);
        neff = int'(n);
        c    = 1'b0;
        case (m)
            3'b001: begin r = (n >= 16) ? 16'h0 : t >> n;  c = (n == 0 || n > 16) ? 1'b0 : t[int'(n) - 1]; end
            3'b010: begin r = (n >= 16) ? 16'h0 : t << n;  c = (n == 0 || n > 16) ? 1'b0 : t[16 - int'(n)]; end
            3'b011: begin r = s >>> ((n > 15) ? 15 : int'(n)); c = (n == 0) ? 1'b0 : t[k - 1]; end
            3'b100: begin tt = tt >> rr; r = tt[15:0];  c = (n == 0) ? 1'b0 : r[15]; end
            3'b101: begin tt = tt << rr; r = tt[31:16]; c = (n == 0) ? 1'b0 : r[0]; end
            default: begin r = t; c = 1'b0; neff = 0; end
        endcase
    endfunction

    // Timing model: cycles of busy left; result commits when it runs out.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_res = 16'h0, p_res = 16'h0;
    logic        m_car = 1'b0, m_zr = 1'b0, p_car = 1'b0;

    always @(posedge clk) begin
        int ne;
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_res = 16'h0; m_car = 1'b0; m_zr = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1; m_res = p_res; m_car = p_car; m_zr = (p_res == 16'h0);
                end
            end else if (start) begin
                ref_op(shiftCtrl, T, shamt, p_res, p_car, ne);
                m_left = ne + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", busy, (m_left > 0));
                chk("done", done, m_done);
                chk("result", Result, m_res);
                chk("carry", carry, m_car);
                chk("zero", zero, m_zr);
            end
        end
    end

    task automatic run_op(input logic [2:0] m, input logic [15:0] t, input logic [4:0] n,
                          input logic [15:0] er, input logic ec, input logic ez,
                          input bit b2b, input bit pulse);
        int cyc, bcnt, lat;
        lat = ((m >= 3'b001 && m <= 3'b101) ? int'(n) : 0) + 2;
        if (!b2b) @(negedge clk);
        start = 1'b1; T = t; shiftCtrl = m; shamt = n;
        @(negedge clk);
        start = 1'b0; T = 16'($urandom); shamt = 5'($urandom); shiftCtrl = 3'($urandom);
        cyc = 1;
        bcnt = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            if (pulse) start = (cyc == 1);
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk("op_timeout", (cyc < 100), 1);
        chk("op_latency", cyc, lat);
        chk("op_busy_cycles", bcnt, lat - 1);
        chk("op_result", Result, er);
        chk("op_carry", carry, ec);
        chk("op_zero", zero, ez);
    endtask

    initial begin
        int seen;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_result", Result, 16'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        chk("rst2_busy", busy, 0);
        chk("rst2_flags", {carry, zero, done}, 0);
        rst = 1'b0; start = 1'b0;

        run_op(3'b010, 16'h8001, 5'd1,  16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(3'b011, 16'h8000, 5'd4,  16'hF800, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(3'b001, 16'h8000, 5'd4,  16'h0800, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(3'b100, 16'h0001, 5'd1,  16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(3'b101, 16'h8001, 5'd4,  16'h0018, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(3'b000, 16'h1234, 5'd7,  16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(3'b001, 16'hFFFF, 5'd20, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(3'b011, 16'h8001, 5'd20, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(3'b100, 16'h0003, 5'd17, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(3'b111, 16'hABCD, 5'd3,  16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(3'b010, 16'h0001, 5'd0,  16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(3'b010, 16'hFFFF, 5'd16, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op(3'b101, 16'h8000, 5'd31, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort a long operation with reset; no completion may follow.
        @(negedge clk);
        start = 1'b1; T = 16'h00FF; shiftCtrl = 3'b001; shamt = 5'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_result", Result, 16'h0);
        chk("abort_carry", carry, 0);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);

        run_op(3'b001, 16'h00F0, 5'd5, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
